// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode encoding and default sizes for the multi-channel PWM DAC
package pwm_pkg;
  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
  localparam int DEF_WIDTH = 13;
  localparam int DEF_NUM_CH = 4;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one double-buffered duty channel; optional output inversion under PWM_POLARITY_EN
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             commit,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] wr_duty,
`ifdef PWM_POLARITY_EN
  input  logic             polarity,
`endif
  output logic             pwm
);
  logic [WIDTH-1:0] shadow, shadow_next, act_duty;
  assign shadow_next = wr_sel ? wr_duty : shadow;
  // shadow takes writes any time; active copy only changes at a period wrap
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shadow <= '0;
      act_duty <= '0;
    end else begin
      shadow <= shadow_next;
      if (commit) act_duty <= shadow_next;
    end
  end
`ifdef PWM_POLARITY_EN
  logic act_pol;
  // polarity is double-buffered alongside the duty
  always_ff @(posedge clk) begin
    if (!reset_n) act_pol <= 1'b0;
    else if (commit) act_pol <= polarity;
  end
  assign pwm = (cnt < act_duty) ^ act_pol;
`else
  assign pwm = cnt < act_duty;
`endif
endmodule

// File: rtl/multi_pwm_dac.sv
// multi_pwm_dac: NUM_CH PWM outputs on a shared edge/center-aligned counter; PWM_POLARITY_EN adds per-channel inversion
module multi_pwm_dac
  import pwm_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int WIDTH  = DEF_WIDTH,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              mode,
  input  logic [WIDTH-1:0]  period,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_duty,
`ifdef PWM_POLARITY_EN
  input  logic [NUM_CH-1:0] polarity,
`endif
  output logic [NUM_CH-1:0] pwm_out,
  output logic              zero,
  output logic              commit
);
  logic [WIDTH-1:0] cnt, act_period;
  logic             dir;
  pwm_mode_e        act_mode;
  logic             wrap;
  // end of period: top of the ramp in edge mode, last down step (or P==0) in center mode
  always_comb begin
    wrap = enable && ((act_mode == PWM_CENTER) ?
                      ((dir && cnt == WIDTH'(1)) || act_period == '0) :
                      (cnt >= act_period));
  end
  assign commit = wrap;
  assign zero = cnt == '0;
  // shared counter; dir=1 means counting down, only used in center mode
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      dir <= 1'b0;
      act_period <= '0;
      act_mode <= PWM_EDGE;
    end else if (wrap) begin
      cnt <= '0;
      dir <= 1'b0;
      act_period <= period;
      act_mode <= pwm_mode_e'(mode);
    end else if (enable) begin
      cnt <= (act_mode == PWM_CENTER && dir) ? cnt - WIDTH'(1) : cnt + WIDTH'(1);
      if (act_mode == PWM_CENTER && !dir && cnt + WIDTH'(1) >= act_period) dir <= 1'b1;
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .commit  (wrap),
      .wr_sel  (wr_en && wr_ch == CH_W'(i)),
      .cnt     (cnt),
      .wr_duty (wr_duty),
`ifdef PWM_POLARITY_EN
      .polarity(polarity[i]),
`endif
      .pwm     (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_multi_pwm_dac.sv
// tb_multi_pwm_dac: random and directed stimulus against a period-position reference model
module tb_multi_pwm_dac;
  localparam int N = 3;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         reset_n, enable, mode, wr_en;
  logic [W-1:0] period, wr_duty;
  logic [1:0]   wr_ch;
  logic [N-1:0] polarity, pwm_out;
  logic         zero, commit;
  always #5 clk = ~clk;
  multi_pwm_dac #(.NUM_CH(N), .WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .mode    (mode),
    .period  (period),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_duty (wr_duty),
`ifdef PWM_POLARITY_EN
    .polarity(polarity),
`endif
    .pwm_out (pwm_out),
    .zero    (zero),
    .commit  (commit)
  );
  int checks = 0, errors = 0;
  int t = 0, m_per = 0, m_mode = 0;
  int sh[N], ad[N];
  logic [N-1:0] ap = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
    end
  endtask
  function automatic int mlen();
    if (m_mode != 0) return (m_per == 0) ? 1 : 2 * m_per;
    return m_per + 1;
  endfunction
  function automatic int mcnt();
    return (m_mode != 0 && t > m_per) ? 2 * m_per - t : t;
  endfunction
  task automatic tick();
    logic [N-1:0] e;
    int c;
    @(negedge clk);
    c = mcnt();
    for (int i = 0; i < N; i++) e[i] = (c < ad[i]) ^ ap[i];
    check("pwm_out", 32'(pwm_out), 32'(e));
    check("zero", 32'(zero), 32'(c == 0));
    check("commit", 32'(commit), 32'(enable && t == mlen() - 1));
    @(posedge clk);
    if (!reset_n) begin
      t = 0; m_per = 0; m_mode = 0; ap = '0;
      for (int i = 0; i < N; i++) begin sh[i] = 0; ad[i] = 0; end
    end else begin
      if (wr_en && wr_ch < N) sh[wr_ch] = wr_duty;
      if (enable) begin
        if (t == mlen() - 1) begin
          t = 0; m_per = period; m_mode = mode;
          for (int i = 0; i < N; i++) ad[i] = sh[i];
`ifdef PWM_POLARITY_EN
          ap = polarity;
`endif
        end else t++;
      end
    end
    #1;
    wr_en = 1'b0;
  endtask
  task automatic write(input int ch, input int d);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_duty = W'(d);
    tick();
  endtask
  task automatic wait_t(input int x);
    int k;
    for (k = 0; k < 600 && t != x; k++) tick();
    check("wait_t bound", 32'(t), 32'(x));
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin sh[i] = 0; ad[i] = 0; end
    reset_n = 1'b0; enable = 1'b1; mode = 1'b0; period = 9;
    wr_en = 1'b0; wr_ch = 0; wr_duty = 0; polarity = 3'b001;
    repeat (2) @(posedge clk);
    #1;
    tick();
    reset_n = 1'b1;
    write(0, 3); write(1, 0); write(2, 10);
    repeat (30) tick();
    mode = 1'b1; period = 8; write(0, 4);
    repeat (40) tick();
    mode = 1'b0; period = 9; write(0, 3);
    repeat (25) tick();
    wait_t(5); write(0, 7);
    repeat (25) tick();
    wait_t(9); write(1, 5); write(3, 9);
    repeat (15) tick();
    wait_t(4); enable = 1'b0;
    repeat (5) tick();
    enable = 1'b1;
    wait_t(6); reset_n = 1'b0; tick(); reset_n = 1'b1;
    repeat (12) tick();
    repeat (3000) begin
      reset_n = $urandom_range(0, 199) != 0;
      enable = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 29) == 0) begin
        mode = 1'($urandom);
        period = W'($urandom_range(0, 12));
        polarity = N'($urandom);
      end
      wr_en = $urandom_range(0, 2) == 0;
      wr_ch = 2'($urandom_range(0, 3));
      wr_duty = W'($urandom_range(0, 14));
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_pwm_dac.md
Name: multi_pwm_dac

Overview:
- Multi-channel PWM DAC: NUM_CH outputs share one period counter.
- Each channel has a double-buffered duty register. A write lands in the shadow copy, and all channels commit together at the period wrap, so duty updates are glitch-free.
- Supports edge-aligned (up count) and center-aligned (up/down) modes. Sits between the control/register logic and the analog output pins, in place of the single-channel DAC.

Parameters:
- NUM_CH, 4, number of PWM channels (>=1).
- WIDTH, 13, width of the counter, period and duty values.
- CH_W, $clog2(NUM_CH) (min 1), width of the channel-select field (localparam).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- enable  input  1  counter advance and commit enable.
- mode  input  1  0 = edge-aligned, 1 = center-aligned; sampled at commit.
- period  input  WIDTH  terminal count P; sampled at commit.
- wr_en  input  1  shadow duty write strobe.
- wr_ch  input  CH_W  channel index for the write.
- wr_duty  input  WIDTH  duty value for the write.
- pwm_out  output  NUM_CH  PWM outputs.
- zero  output  1  high while cnt == 0.
- commit  output  1  high in the cycle whose ending edge commits the shadow values.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - cnt=0, dir=up.
  - act_period=0, act_mode=edge.
  - All shadow and active duties = 0.
  - Outputs after reset: pwm_out=0, zero=1, commit=enable.
- Edge mode:
  - cnt goes 0,1..P,0. Period is P+1 cycles.
  - wrap = enable && cnt >= act_period; cnt then goes to 0.
- Center mode:
  - cnt goes 0,1..P,P-1..1,0. Period is 2P cycles.
  - dir flips to down on the edge where cnt reaches P, and to up at 0.
  - wrap = enable && ((dir==down && cnt==1) || act_period==0); cnt then goes to 0 and dir to up.
  - P==0: cnt stays at 0 and wrap occurs every enabled cycle.
- Commit (edge at end of a wrap cycle):
  - act_period<=period, act_mode<=mode, act_duty[i]<=shadow_next[i] for all i.
  - Counting after a commit follows the new act_period/act_mode.
- Shadow write:
  - wr_en=1 with wr_ch < NUM_CH sets shadow[wr_ch]<=wr_duty.
  - wr_ch >= NUM_CH is ignored.
  - A write in the same cycle as a wrap is committed on that edge (shadow_next includes the write).
- pwm_out[i] is combinational: (cnt < act_duty[i]).
  - duty 0 gives constant 0.
  - Edge mode: duty >= P+1 gives constant 1.
  - Center mode: duty > P gives constant 1. The output is symmetric about the peak, so the high time is 2*duty-1 cycles for 1<=duty<=P.
- enable=0:
  - cnt and dir hold, no commit occurs, commit=0.
  - Shadow writes are still accepted.
  - pwm_out and zero keep reflecting the held cnt.
- zero = (cnt==0). commit = wrap.
- Reset mid-period: everything returns to the reset values on the next edge. Uncommitted shadow writes are lost.

Optional Feature:
- Macro: PWM_POLARITY_EN.
- Defined:
  - Adds input polarity[NUM_CH-1:0] and a per-channel act_pol register (reset to 0).
  - act_pol<=polarity at commit.
  - pwm_out[i] = (cnt < act_duty[i]) ^ act_pol[i].
  - In reset, outputs are still 0 because act_pol=0.
- Not defined: the polarity port and act_pol register are absent, and outputs are non-inverted.

Decomposition:
- Package pwm_pkg:
  - typedef enum logic {PWM_EDGE=1'b0, PWM_CENTER=1'b1} pwm_mode_e.
  - Default-width constants for WIDTH and NUM_CH.
- Sub-module pwm_channel, instantiated NUM_CH times from a generate loop. It holds the shadow and active duty (and act_pol when enabled), and takes cnt, commit, wr_sel and wr_duty.
- The counter, dir and mode/period logic stay in the top level.

Test Plan:
- Edge mode, P=9:
  - Stimulus: reset, enable=1, write ch0 duty=3, ch1 duty=0, ch2 duty=10.
  - Response: after the first commit, ch0 is high for 3 of 10 cycles, ch1 is constantly 0, ch2 is constantly 1. zero pulses every 10 cycles.
- Center mode, P=8, ch0 duty=4:
  - Response: period is 16 cycles. ch0 is high for cnt 0..3 on both ramps, i.e. 7 cycles, symmetric about the peak. commit goes high in the cycle where cnt=1 and dir=down.
- Mid-period write, edge mode, P=9, ch0 duty 3 to 7:
  - Stimulus: write ch0 duty=7 at cnt=5.
  - Response: the current period still uses 3. The next period uses 7 from cnt=0, with no runt pulse.
- Write in the same cycle as wrap:
  - Response: the new duty appears in the immediately following period.
  - A write with wr_ch=NUM_CH leaves all channels unchanged.
- enable=0 for 5 cycles at cnt=4:
  - Response: cnt holds at 4, no commit occurs, and pwm_out stays stable.
  - Deasserting reset_n at cnt=6 gives cnt=0, pwm_out=0 and act duties=0 on the next edge.
- PWM_POLARITY_EN:
  - Stimulus: polarity=4'b0001, ch0 duty=3, P=9.
  - Response: ch0 is low for 3 of 10 cycles after the commit. Other channels are unaffected.
